// File: rtl/frog_life_ctrl.sv
// Frogger collision sequencer and life manager: per-frame probe latching and play/dying/respawn FSM.
// Optional post-respawn invulnerability is enabled by defining INVULN_EN.
module frog_life_ctrl #(
    parameter int VRES         = 480,
    parameter int PROBE_OFF    = 16,
    parameter int FROG_SIZE    = 32,
    parameter int LIVES_INIT   = 3,
    parameter int DYING_FRAMES = 60,
    parameter int BLINK_SHIFT  = 3,
    parameter int GRACE_FRAMES = 120
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] hc,
    input  logic [9:0] vc,
    input  logic       croc_pix,
    input  logic [9:0] FrogX,
    input  logic [9:0] FrogY,
    input  logic       start,
    output logic       frog_visible,
    output logic       freeze,
    output logic       respawn,
    output logic       dead_pulse,
    output logic [2:0] lives,
    output logic       game_over
);

    localparam int CW = 16;
    localparam logic [CW-1:0] LAST  = CW'(DYING_FRAMES - 1);
    localparam logic [2:0]    LIVES0 = 3'(LIVES_INIT);

    typedef enum logic [2:0] {
        IDLE,
        RESPAWN,
        PLAY,
        DYING,
        OVER
    } state_t;

    state_t        state_q, state_n;
    logic [2:0]    lives_q, lives_n;
    logic [CW-1:0] cnt_q, cnt_n;
    logic [3:0]    probe_q, pt_hit;
    logic          start_q;
    logic          frame_start, frame_end, hit;
    logic          guard, vis_play;
    logic          vis_n, freeze_n, respawn_n, dead_n, over_n;

    // Probe points carry an extra bit so a wrapped coordinate never matches.
    logic [10:0] xm, xf, ym, yf;

    assign xm = {1'b0, FrogX} + 11'(PROBE_OFF);
    assign xf = {1'b0, FrogX} + 11'(FROG_SIZE);
    assign ym = {1'b0, FrogY} + 11'(PROBE_OFF);
    assign yf = {1'b0, FrogY} + 11'(FROG_SIZE);

    assign frame_start = (hc == 10'd0) && (vc == 10'd0);
    assign frame_end   = (hc == 10'd0) && (vc == 10'(VRES));

    always_comb begin
        pt_hit    = 4'b0000;
        pt_hit[3] = (hc == FrogX) && !ym[10] && (vc == ym[9:0]);
        pt_hit[2] = !xf[10] && (hc == xf[9:0])
                    && !ym[10] && (vc == ym[9:0]);
        pt_hit[1] = !xm[10] && (hc == xm[9:0]) && (vc == FrogY);
        pt_hit[0] = !xm[10] && (hc == xm[9:0])
                    && !yf[10] && (vc == yf[9:0]);
        if (!croc_pix) begin
            pt_hit = 4'b0000;
        end
    end

    // Latches are held clear outside PLAY so no stale hit survives a respawn.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            probe_q <= 4'b0000;
        end else if (frame_start || state_q != PLAY) begin
            probe_q <= 4'b0000;
        end else begin
            probe_q <= probe_q | pt_hit;
        end
    end

    assign hit = |probe_q;

`ifdef INVULN_EN
    logic [CW-1:0] grace_q, grace_n;

    assign guard = (grace_q != '0);

    always_comb begin
        grace_n = grace_q;
        if (state_q == RESPAWN) begin
            grace_n = CW'(GRACE_FRAMES);
        end else if (state_q == PLAY && frame_end && guard) begin
            grace_n = grace_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grace_q <= '0;
        end else begin
            grace_q <= grace_n;
        end
    end

    assign vis_play = (grace_n == '0) || !grace_n[BLINK_SHIFT];
`else
    assign guard    = 1'b0;
    assign vis_play = 1'b1;
`endif

    always_comb begin
        state_n = state_q;
        lives_n = lives_q;
        cnt_n   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start && !start_q) begin
                    state_n = RESPAWN;
                    lives_n = LIVES0;
                end
            end
            RESPAWN: begin
                state_n = PLAY;
            end
            PLAY: begin
                if (frame_end && hit && !guard) begin
                    state_n = DYING;
                    lives_n = (lives_q == 3'd0) ? 3'd0 : lives_q - 3'd1;
                    cnt_n   = '0;
                end
            end
            DYING: begin
                if (frame_end) begin
                    cnt_n = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_n = (lives_q == 3'd0) ? OVER : RESPAWN;
                    end
                end
            end
            OVER: begin
                if (start) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Outputs are registered alongside the state they describe.
    always_comb begin
        respawn_n = (state_n == RESPAWN);
        dead_n    = (state_q == PLAY) && (state_n == DYING);
        freeze_n  = (state_n != PLAY);
        over_n    = (state_n == OVER);
        vis_n     = 1'b0;
        if (state_n == PLAY) begin
            vis_n = vis_play;
        end else if (state_n == DYING) begin
            vis_n = !cnt_n[BLINK_SHIFT];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            lives_q      <= LIVES0;
            cnt_q        <= '0;
            start_q      <= 1'b0;
            frog_visible <= 1'b0;
            freeze       <= 1'b1;
            respawn      <= 1'b0;
            dead_pulse   <= 1'b0;
            game_over    <= 1'b0;
        end else begin
            state_q      <= state_n;
            lives_q      <= lives_n;
            cnt_q        <= cnt_n;
            start_q      <= start;
            frog_visible <= vis_n;
            freeze       <= freeze_n;
            respawn      <= respawn_n;
            dead_pulse   <= dead_n;
            game_over    <= over_n;
        end
    end

    assign lives = lives_q;

endmodule

// File: tb/tb_frog_life_ctrl.sv
// Directed bench for frog_life_ctrl: probes, frame clearing, wrap rejection,
// dying blink, game over and restart.
module tb_frog_life_ctrl;

    localparam logic [9:0] VRES = 10'd480;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] hc, vc;
    logic       croc_pix;
    logic [9:0] FrogX, FrogY;
    logic       start;
    logic       frog_visible, freeze, respawn, dead_pulse, game_over;
    logic [2:0] lives;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    frog_life_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .hc           (hc),
        .vc           (vc),
        .croc_pix     (croc_pix),
        .FrogX        (FrogX),
        .FrogY        (FrogY),
        .start        (start),
        .frog_visible (frog_visible),
        .freeze       (freeze),
        .respawn      (respawn),
        .dead_pulse   (dead_pulse),
        .lives        (lives),
        .game_over    (game_over)
    );

    task automatic step(input logic [9:0] h, input logic [9:0] v, input logic c);
        hc = h;
        vc = v;
        croc_pix = c;
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic [9:0] h, input logic [9:0] v, input logic c);
        step(10'd0, 10'd0, 1'b0);
        step(h, v, c);
        step(10'd5, 10'd5, 1'b0);
        step(10'd0, VRES, 1'b0);
    endtask

    task automatic settle_grace;
`ifdef INVULN_EN
        for (int i = 0; i < 120; i++) frame(10'd5, 10'd5, 1'b0);
`endif
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) step(10'd5, 10'd5, 1'b0);
        checks++; if (lives !== 3'd3) begin errors++; $display("FAIL reset_lives got %0d want 3", lives); end
        checks++; if (freeze !== 1'b1) begin errors++; $display("FAIL reset_freeze got %b want 1", freeze); end
        checks++; if (frog_visible !== 1'b0) begin errors++; $display("FAIL reset_vis got %b want 0", frog_visible); end
        checks++; if (respawn !== 1'b0) begin errors++; $display("FAIL reset_respawn got %b want 0", respawn); end
        checks++; if (dead_pulse !== 1'b0) begin errors++; $display("FAIL reset_dead got %b want 0", dead_pulse); end
        checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL reset_over got %b want 0", game_over); end
        rst_n = 1'b1;
        step(10'd5, 10'd5, 1'b0);
        checks++; if (respawn !== 1'b0 || freeze !== 1'b1) begin errors++; $display("FAIL idle_hold got respawn=%b freeze=%b want 0/1", respawn, freeze); end
    endtask

    task automatic test_start;
        start = 1'b1;
        step(10'd5, 10'd5, 1'b0);
        start = 1'b0;
        checks++; if (respawn !== 1'b1) begin errors++; $display("FAIL start_respawn got %b want 1", respawn); end
        step(10'd5, 10'd5, 1'b0);
        checks++; if (respawn !== 1'b0) begin errors++; $display("FAIL respawn_width got %b want 0", respawn); end
        checks++; if (freeze !== 1'b0) begin errors++; $display("FAIL play_freeze got %b want 0", freeze); end
        checks++; if (lives !== 3'd3) begin errors++; $display("FAIL play_lives got %0d want 3", lives); end
        settle_grace();
        checks++; if (frog_visible !== 1'b1) begin errors++; $display("FAIL play_vis got %b want 1", frog_visible); end
    endtask

    task automatic test_no_hit;
        logic [9:0] th [3];
        logic [9:0] tv [3];
        logic       tc [3];
        th = '{10'd101, 10'd132, 10'd5};
        tv = '{10'd216, 10'd216, 10'd5};
        tc = '{1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 3; i++) begin
            frame(th[i], tv[i], tc[i]);
            checks++;
            if (dead_pulse !== 1'b0 || freeze !== 1'b0 || lives !== 3'd3) begin
                errors++;
                $display("FAIL no_hit_%0d got dead=%b freeze=%b lives=%0d want 0/0/3", i, dead_pulse, freeze, lives);
            end
        end
    endtask

    task automatic test_frame_start_clear;
        FrogY = 10'd470;
        step(10'd116, 10'd502, 1'b1);
        frame(10'd5, 10'd5, 1'b0);
        checks++; if (dead_pulse !== 1'b0 || freeze !== 1'b0) begin errors++; $display("FAIL vblank_clear got dead=%b freeze=%b want 0/0", dead_pulse, freeze); end
        FrogY = 10'd200;
    endtask

    task automatic test_frame_end_edge;
        FrogX = 10'd0;
        FrogY = 10'd464;
        step(10'd0, 10'd0, 1'b0);
        step(10'd5, 10'd5, 1'b0);
        step(10'd0, VRES, 1'b1);
        checks++; if (dead_pulse !== 1'b0) begin errors++; $display("FAIL end_same_cycle got dead=%b want 0", dead_pulse); end
        frame(10'd5, 10'd5, 1'b0);
        checks++; if (dead_pulse !== 1'b0 || freeze !== 1'b0) begin errors++; $display("FAIL end_then_clear got dead=%b freeze=%b want 0/0", dead_pulse, freeze); end
        FrogX = 10'd100;
        FrogY = 10'd200;
    endtask

    task automatic test_wrap;
        FrogX = 10'd1010;
        frame(10'd18, 10'd216, 1'b1);
        checks++; if (dead_pulse !== 1'b0 || freeze !== 1'b0) begin errors++; $display("FAIL wrap_p2 got dead=%b freeze=%b want 0/0", dead_pulse, freeze); end
        frame(10'd2, 10'd200, 1'b1);
        checks++; if (dead_pulse !== 1'b0 || freeze !== 1'b0) begin errors++; $display("FAIL wrap_p1 got dead=%b freeze=%b want 0/0", dead_pulse, freeze); end
        FrogX = 10'd100;
    endtask

    task automatic test_death(input logic [9:0] h, input logic [9:0] v, input logic [2:0] exp_lives);
        frame(h, v, 1'b1);
        checks++; if (dead_pulse !== 1'b1) begin errors++; $display("FAIL death_pulse got %b want 1", dead_pulse); end
        checks++; if (lives !== exp_lives) begin errors++; $display("FAIL death_lives got %0d want %0d", lives, exp_lives); end
        checks++; if (freeze !== 1'b1 || frog_visible !== 1'b1) begin errors++; $display("FAIL death_out got freeze=%b vis=%b want 1/1", freeze, frog_visible); end
        step(10'd5, 10'd5, 1'b0);
        checks++; if (dead_pulse !== 1'b0) begin errors++; $display("FAIL dead_width got %b want 0", dead_pulse); end
    endtask

    task automatic test_dying(input bit hold_start, input bit exp_over);
        logic exp_vis;
        for (int k = 1; k <= 60; k++) begin
            start = hold_start && (k <= 10);
            frame(10'd5, 10'd5, 1'b0);
            if (k < 60) begin
                exp_vis = ((k >> 3) & 1) == 0;
                checks++;
                if (frog_visible !== exp_vis || respawn !== 1'b0) begin
                    errors++;
                    $display("FAIL blink_%0d got vis=%b respawn=%b want %b/0", k, frog_visible, respawn, exp_vis);
                end
            end else if (exp_over) begin
                checks++;
                if (game_over !== 1'b1 || freeze !== 1'b1 || frog_visible !== 1'b0 || respawn !== 1'b0) begin
                    errors++;
                    $display("FAIL over_entry got over=%b freeze=%b vis=%b respawn=%b want 1/1/0/0", game_over, freeze, frog_visible, respawn);
                end
            end else begin
                checks++;
                if (respawn !== 1'b1) begin errors++; $display("FAIL dying_respawn got %b want 1", respawn); end
            end
        end
        start = 1'b0;
        if (!exp_over) begin
            step(10'd5, 10'd5, 1'b0);
            checks++; if (respawn !== 1'b0 || freeze !== 1'b0) begin errors++; $display("FAIL back_to_play got respawn=%b freeze=%b want 0/0", respawn, freeze); end
        end
    endtask

    task automatic test_first_frame;
`ifdef INVULN_EN
        for (int i = 1; i <= 120; i++) begin
            frame(10'd100, 10'd216, 1'b1);
            checks++;
            if (dead_pulse !== 1'b0 || freeze !== 1'b0) begin
                errors++;
                $display("FAIL grace_%0d got dead=%b freeze=%b want 0/0", i, dead_pulse, freeze);
            end
        end
`endif
        test_death(10'd100, 10'd216, 3'd1);
    endtask

    task automatic test_over_restart;
        frame(10'd5, 10'd5, 1'b0);
        checks++; if (game_over !== 1'b1 || lives !== 3'd0) begin errors++; $display("FAIL over_hold got over=%b lives=%0d want 1/0", game_over, lives); end
        start = 1'b1;
        step(10'd5, 10'd5, 1'b0);
        checks++; if (game_over !== 1'b0 || freeze !== 1'b1) begin errors++; $display("FAIL over_to_idle got over=%b freeze=%b want 0/1", game_over, freeze); end
        step(10'd5, 10'd5, 1'b0);
        checks++; if (respawn !== 1'b0) begin errors++; $display("FAIL held_start got respawn=%b want 0", respawn); end
        start = 1'b0;
        step(10'd5, 10'd5, 1'b0);
        start = 1'b1;
        step(10'd5, 10'd5, 1'b0);
        start = 1'b0;
        checks++; if (respawn !== 1'b1 || lives !== 3'd3) begin errors++; $display("FAIL restart got respawn=%b lives=%0d want 1/3", respawn, lives); end
        step(10'd5, 10'd5, 1'b0);
        checks++; if (freeze !== 1'b0 || game_over !== 1'b0) begin errors++; $display("FAIL restart_play got freeze=%b over=%b want 0/0", freeze, game_over); end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        hc = 10'd5;
        vc = 10'd5;
        croc_pix = 1'b0;
        FrogX = 10'd100;
        FrogY = 10'd200;
        test_reset();
        test_start();
        test_no_hit();
        test_frame_start_clear();
        test_frame_end_edge();
        test_wrap();
        test_death(10'd132, 10'd216, 3'd2);
        test_dying(1'b1, 1'b0);
        test_first_frame();
        test_dying(1'b0, 1'b0);
        settle_grace();
        test_death(10'd116, 10'd200, 3'd0);
        test_dying(1'b0, 1'b1);
        test_over_restart();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
